// File: rtl/a51_pkg.sv
// a51_pkg: shared constants for the A5/1 keystream generator -- register
// lengths, feedback tap masks, clock-control bit positions, default frame
// parameters and the sequencing FSM state type.
// Optional build feature: A51_DUAL_BURST_EN (handled in a51_keystream).
package a51_pkg;

    // Register lengths
    localparam int R1_LEN = 19;
    localparam int R2_LEN = 22;
    localparam int R3_LEN = 23;

    // Feedback taps: R1 bits 18,17,16,13; R2 bits 21,20; R3 bits 22,21,20,7
    localparam logic [R1_LEN-1:0] R1_TAPS = 19'h7_2000;
    localparam logic [R2_LEN-1:0] R2_TAPS = 22'h30_0000;
    localparam logic [R3_LEN-1:0] R3_TAPS = 23'h70_0080;

    // Clock-control (majority vote) bit positions
    localparam int R1_CLKBIT = 8;
    localparam int R2_CLKBIT = 10;
    localparam int R3_CLKBIT = 10;

    // Default frame parameters
    localparam int DEF_KEYLEN      = 64;
    localparam int DEF_FRAMENUMLEN = 22;
    localparam int DEF_MIXCYCLES   = 100;
    localparam int DEF_BURSTLEN    = 228;

    // Sequencing FSM
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_KEY   = 3'd1,
        LOAD_FRAME = 3'd2,
        MIX        = 3'd3,
        RUN        = 3'd4
    } a51_state_e;

    // Phase counter width: ceil(log2(BURSTLEN+1)) for the default build, and
    // never narrower than any other phase length it has to count through.
    function automatic int cnt_width(input int burst, input int keylen,
                                     input int frmlen, input int mixlen);
        int m;
        m = burst;
        if (keylen > m) m = keylen;
        if (frmlen > m) m = frmlen;
        if (mixlen > m) m = mixlen;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/a51_lfsr.sv
// a51_lfsr: one A5/1 shift register. A shift moves the register left by one
// and writes the XOR of the tap bits into bit 0; an injection XORs a key or
// frame bit into bit 0 after the shift. Exposes the MSB, the bit that will
// become the MSB on the next shift, and the clock-control bit.
module a51_lfsr
    import a51_pkg::*;
#(
    parameter int              LEN     = R1_LEN,
    parameter logic [LEN-1:0]  TAPMASK = R1_TAPS,
    parameter int              CLKBIT  = R1_CLKBIT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic shift_en,
    input  logic inject_en,
    input  logic inject_bit,
    output logic msb,
    output logic msb_ahead,
    output logic clkbit
);

    logic [LEN-1:0] reg_q;
    logic [LEN-1:0] reg_d;
    logic           feedback;

    // Next state: clear wins; otherwise optional shift then optional injection into bit 0
    always_comb begin
        feedback = ^(reg_q & TAPMASK);
        reg_d    = reg_q;
        if (clear) begin
            reg_d = '0;
        end else begin
            if (shift_en) begin
                reg_d = {reg_q[LEN-2:0], feedback};
            end
            if (inject_en) begin
                reg_d[0] = reg_d[0] ^ inject_bit;
            end
        end
    end

    // Register state, cleared asynchronously
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reg_q <= '0;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign msb       = reg_q[LEN-1];
    assign msb_ahead = reg_q[LEN-2];
    assign clkbit    = reg_q[CLKBIT];

endmodule

// File: rtl/a51_keystream.sv
// a51_keystream: A5/1 keystream generator. Loads the session key and frame
// number into three LFSRs, mixes for MIXCYCLES majority-clocked cycles, then
// streams BURSTLEN keystream bits over a valid/ready handshake.
// Optional build feature: A51_DUAL_BURST_EN adds ks_dir (downlink/uplink half
// indicator) and an extra done pulse after the first half of the burst.
module a51_keystream
    import a51_pkg::*;
#(
    parameter int KEYLEN      = DEF_KEYLEN,
    parameter int FRAMENUMLEN = DEF_FRAMENUMLEN,
    parameter int MIXCYCLES   = DEF_MIXCYCLES,
    parameter int BURSTLEN    = DEF_BURSTLEN
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [KEYLEN-1:0]      key,
    input  logic [FRAMENUMLEN-1:0] frame,
    output logic                   busy,
    output logic                   ks_valid,
    input  logic                   ks_ready,
    output logic                   ks_bit,
`ifdef A51_DUAL_BURST_EN
    output logic                   ks_dir,
`endif
    output logic                   done
);

    localparam int CNT_W  = cnt_width(BURSTLEN, KEYLEN, FRAMENUMLEN, MIXCYCLES);
    localparam int KEY_IW = $clog2(KEYLEN);
    localparam int FRM_IW = $clog2(FRAMENUMLEN);

    localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEYLEN - 1);
    localparam logic [CNT_W-1:0] FRM_LAST   = CNT_W'(FRAMENUMLEN - 1);
    localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIXCYCLES - 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURSTLEN - 1);
`ifdef A51_DUAL_BURST_EN
    localparam logic [CNT_W-1:0] HALF       = CNT_W'(BURSTLEN / 2);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(BURSTLEN / 2 - 1);
`endif

    a51_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [KEYLEN-1:0]      key_q, key_d;
    logic [FRAMENUMLEN-1:0] frame_q, frame_d;
    logic                   done_q, done_d;

    logic       clear_regs;
    logic       shift_all;
    logic       shift_maj;
    logic       inject_en;
    logic       inject_bit;
    logic       maj;
    logic [2:0] msb;
    logic [2:0] msb_ahead;
    logic [2:0] clkbit;
    logic [2:0] step_sel;
    logic [2:0] shift_en;
    logic [2:0] out_bit;

    // Sequencing: phase transitions, phase counter, register strobes and done generation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        key_d      = key_q;
        frame_d    = frame_q;
        done_d     = 1'b0;
        clear_regs = 1'b0;
        shift_all  = 1'b0;
        shift_maj  = 1'b0;
        inject_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d      = key;
                    frame_d    = frame;
                    clear_regs = 1'b1;
                    cnt_d      = '0;
                    state_d    = LOAD_KEY;
                end
            end
            LOAD_KEY: begin
                shift_all = 1'b1;
                inject_en = 1'b1;
                if (cnt_q == KEY_LAST) begin
                    cnt_d   = '0;
                    state_d = LOAD_FRAME;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOAD_FRAME: begin
                shift_all = 1'b1;
                inject_en = 1'b1;
                if (cnt_q == FRM_LAST) begin
                    cnt_d   = '0;
                    state_d = MIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MIX: begin
                shift_maj = 1'b1;
                if (cnt_q == MIX_LAST) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (ks_ready) begin
                    shift_maj = 1'b1;
                    if (cnt_q == BURST_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`ifdef A51_DUAL_BURST_EN
                    if (cnt_q == HALF_LAST) begin
                        done_d = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state, cleared asynchronously so a reset abandons any frame in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            frame_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end

    // Key bit j during LOAD_KEY, frame bit j during LOAD_FRAME
    assign inject_bit = (state_q == LOAD_FRAME) ? frame_q[cnt_q[FRM_IW-1:0]]
                                                : key_q[cnt_q[KEY_IW-1:0]];

    assign maj = (clkbit[0] & clkbit[1]) | (clkbit[0] & clkbit[2]) | (clkbit[1] & clkbit[2]);

    // Per-register clock control. Keystream bit i is defined on the registers
    // after their (i+1)-th post-mix majority step, so the output previews the
    // MSB each register will hold once the pending step is taken; the step
    // commits only on a transfer, so ks_bit stays stable while stalled.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ctl
            assign step_sel[gi] = (clkbit[gi] == maj);
            assign shift_en[gi] = shift_all | (shift_maj & step_sel[gi]);
            assign out_bit[gi]  = step_sel[gi] ? msb_ahead[gi] : msb[gi];
        end
    endgenerate

    a51_lfsr #(.LEN(R1_LEN), .TAPMASK(R1_TAPS), .CLKBIT(R1_CLKBIT)) u_r1 (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (clear_regs),
        .shift_en   (shift_en[0]),
        .inject_en  (inject_en),
        .inject_bit (inject_bit),
        .msb        (msb[0]),
        .msb_ahead  (msb_ahead[0]),
        .clkbit     (clkbit[0])
    );

    a51_lfsr #(.LEN(R2_LEN), .TAPMASK(R2_TAPS), .CLKBIT(R2_CLKBIT)) u_r2 (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (clear_regs),
        .shift_en   (shift_en[1]),
        .inject_en  (inject_en),
        .inject_bit (inject_bit),
        .msb        (msb[1]),
        .msb_ahead  (msb_ahead[1]),
        .clkbit     (clkbit[1])
    );

    a51_lfsr #(.LEN(R3_LEN), .TAPMASK(R3_TAPS), .CLKBIT(R3_CLKBIT)) u_r3 (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (clear_regs),
        .shift_en   (shift_en[2]),
        .inject_en  (inject_en),
        .inject_bit (inject_bit),
        .msb        (msb[2]),
        .msb_ahead  (msb_ahead[2]),
        .clkbit     (clkbit[2])
    );

    assign busy     = (state_q != IDLE);
    assign ks_valid = (state_q == RUN);
    assign ks_bit   = ks_valid & (^out_bit);
    assign done     = done_q;
`ifdef A51_DUAL_BURST_EN
    assign ks_dir   = ks_valid & (cnt_q >= HALF);
`endif

endmodule

// File: tb/tb_a51_keystream.sv
// tb_a51_keystream: directed bench for a51_keystream with an algorithmic A5/1
// reference model and a per-cycle output monitor.
// Optional build feature: A51_DUAL_BURST_EN (ks_dir, two done pulses per frame).
module tb_a51_keystream;

    localparam int BURSTLEN = 228;
    localparam int HALF     = 114;
    localparam int LATENCY  = 186;
    localparam logic [63:0] KEY_REF = 64'hEFCD_AB89_6745_2312;
    localparam logic [21:0] FRM_REF = 22'h134;
`ifdef A51_DUAL_BURST_EN
    localparam int DONES = 2;
`else
    localparam int DONES = 1;
`endif

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [63:0] key;
    logic [21:0] frame;
    logic        busy;
    logic        ks_valid;
    logic        ks_ready;
    logic        ks_bit;
    logic        done;
`ifdef A51_DUAL_BURST_EN
    logic        ks_dir;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int exp_idx = 0;
    int frames_done = 0;
    int dones_this = 0;
    int last_dones = 0;
    logic [BURSTLEN-1:0] exp_stream = '0;

    a51_keystream dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .key      (key),
        .frame    (frame),
        .busy     (busy),
        .ks_valid (ks_valid),
        .ks_ready (ks_ready),
        .ks_bit   (ks_bit),
`ifdef A51_DUAL_BURST_EN
        .ks_dir   (ks_dir),
`endif
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One register step: shift left, XOR of tapped bits into bit 0
    function automatic int unsigned lfsr_step(input int unsigned v, input int unsigned len,
                                              input int unsigned tp);
        int unsigned fb;
        fb = 32'($countones(v & tp)) & 32'd1;
        return ((v << 1) | fb) & ((32'd1 << len) - 32'd1);
    endfunction

    // Reference A5/1: 64 key + 22 frame loading steps, 100 discarded majority
    // steps, then each output bit is taken after one more majority step.
    function automatic logic [BURSTLEN-1:0] a51_ref(input logic [63:0] k, input logic [21:0] f);
        int unsigned r [3];
        int unsigned lens [3];
        int unsigned taps [3];
        int unsigned cbit [3];
        int unsigned c [3];
        int unsigned votes;
        int unsigned m;
        int unsigned b;
        logic [BURSTLEN-1:0] s;
        lens = '{19, 22, 23};
        taps = '{32'h72000, 32'h300000, 32'h700080};
        cbit = '{8, 10, 10};
        r    = '{0, 0, 0};
        s    = '0;
        for (int i = 0; i < 86; i++) begin
            if (i < 64) b = 32'(k[i]);
            else        b = 32'(f[i-64]);
            for (int n = 0; n < 3; n++) r[n] = lfsr_step(r[n], lens[n], taps[n]) ^ b;
        end
        for (int i = 0; i < 100 + BURSTLEN; i++) begin
            votes = 0;
            for (int n = 0; n < 3; n++) begin
                c[n]  = (r[n] >> cbit[n]) & 32'd1;
                votes = votes + c[n];
            end
            m = (votes >= 2) ? 32'd1 : 32'd0;
            for (int n = 0; n < 3; n++) if (c[n] == m) r[n] = lfsr_step(r[n], lens[n], taps[n]);
            if (i >= 100) s[i-100] = 1'(((r[0] >> 18) ^ (r[1] >> 21) ^ (r[2] >> 22)) & 32'd1);
        end
        return s;
    endfunction

    // Monitor: checks every valid bit against the expected stream, the done
    // position and (when built) ks_dir, on the falling edge.
    always @(negedge clock) begin
        if (!reset_n) begin
            exp_idx    = 0;
            dones_this = 0;
        end else begin
            if (done) begin
                dones_this++;
                if (exp_idx == BURSTLEN) begin
                    check("done_idle", {126'd0, busy, ks_valid}, 128'd0);
                    frames_done++;
                    last_dones = dones_this;
                    dones_this = 0;
                    exp_idx    = 0;
                    $display("frame %0d complete: %0d bits transferred", frames_done, BURSTLEN);
                end else begin
`ifdef A51_DUAL_BURST_EN
                    check("done_half_pos", 128'(exp_idx), 128'(HALF));
                    check("done_half_busy", {126'd0, busy, ks_valid}, 128'd3);
`else
                    check("done_pos", 128'(exp_idx), 128'(BURSTLEN));
`endif
                end
            end
`ifdef A51_DUAL_BURST_EN
            check("ks_dir", 128'(ks_dir), 128'(ks_valid && (exp_idx >= HALF)));
`endif
            if (ks_valid) begin
                if (exp_idx >= BURSTLEN) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL ks_overrun: got valid bit %0d, expected at most %0d", exp_idx, BURSTLEN);
                end else begin
                    check($sformatf("ks_bit[%0d]", exp_idx), 128'(ks_bit), 128'(exp_stream[exp_idx]));
                end
                if (ks_ready) exp_idx++;
            end
        end
    end

    task automatic start_frame(input logic [63:0] k, input logic [21:0] f);
        @(posedge clock); #1;
        key   = k;
        frame = f;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit rnd, input int limit);
        int base;
        base = frames_done;
        for (int c = 0; c < limit; c++) begin
            @(posedge clock); #1;
            if (frames_done != base) return;
            if (rnd) ks_ready = ($urandom_range(0, 1) == 1);
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_done: got no done within %0d cycles, expected one", limit);
    endtask

    task automatic wait_idx(input int target, input int limit);
        for (int c = 0; c < limit; c++) begin
            @(posedge clock); #1;
            if (exp_idx >= target) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_idx: got index %0d, expected to reach %0d", exp_idx, target);
    endtask

    task automatic check_quiet(input string name);
        check(name, {124'd0, busy, ks_valid, ks_bit, done}, 128'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [BURSTLEN-1:0] mref;
        logic [BURSTLEN-1:0] mzero;
        logic [119:0] pa;
        logic [119:0] pb;
        int lat;
        int fb;

        reset_n  = 1'b1;
        start    = 1'b0;
        key      = '0;
        frame    = '0;
        ks_ready = 1'b1;
        #2 reset_n = 1'b0;
        #1 check_quiet("reset_async");
        repeat (2) @(posedge clock);
        #1 check_quiet("reset_held");
        #2 reset_n = 1'b1;

        // Pin the model to the published reference vector and the zero case
        mref  = a51_ref(KEY_REF, FRM_REF);
        mzero = a51_ref(64'd0, 22'd0);
        pa = '0;
        pb = '0;
        for (int i = 0; i < HALF; i++) begin
            pa[119-i] = mref[i];
            pb[119-i] = mref[HALF+i];
        end
        check("model_downlink", 128'(pa), 128'(120'h534EAA582FE8151AB6E1855A728C00));
        check("model_uplink",   128'(pb), 128'(120'h24FD35A35D5FB6526D32F906DF1AC0));
        check("model_zero", 128'(mzero == '0), 128'd1);

        // Reference frame, ready held high; latency and a start ignored mid-load
        exp_stream = mref;
        start_frame(KEY_REF, FRM_REF);
        lat = 0;
        while (!ks_valid && lat < 400) begin
            @(posedge clock); #1;
            lat++;
            if (lat == 50) begin
                start = 1'b1;
                key   = ~KEY_REF;
                frame = ~FRM_REF;
            end else if (lat == 51) begin
                start = 1'b0;
                key   = KEY_REF;
                frame = FRM_REF;
            end
        end
        $display("reference frame: first ks_valid %0d cycles after start", lat);
        check("latency", 128'(lat), 128'(LATENCY));
        wait_done(1'b0, 1000);
        check("dones_ref", 128'(last_dones), 128'(DONES));

        // All-zero frame, with a start held from near its end: ignored while
        // busy, accepted in the cycle done pulses
        exp_stream = mzero;
        start_frame(64'd0, 22'd0);
        wait_idx(200, 1000);
        key   = KEY_REF;
        frame = FRM_REF;
        start = 1'b1;
        wait_done(1'b0, 1000);
        start = 1'b0;
        check("dones_zero", 128'(last_dones), 128'(DONES));
        check("b2b_accept", 128'(busy), 128'd1);

        // Back-to-back reference frame with a randomly stalling consumer
        exp_stream = mref;
        wait_done(1'b1, 4000);
        ks_ready = 1'b1;
        check("dones_random", 128'(last_dones), 128'(DONES));

        // Reset in the middle of RUN, then a clean restart
        start_frame(KEY_REF, FRM_REF);
        wait_idx(40, 1000);
        #2 reset_n = 1'b0;
        #1 check_quiet("reset_midframe");
        fb = frames_done;
        repeat (3) @(posedge clock);
        #3 reset_n = 1'b1;
        check_quiet("after_reset");
        start_frame(KEY_REF, FRM_REF);
        wait_done(1'b0, 1000);
        check("frames_after_reset", 128'(frames_done), 128'(fb + 1));
        check("dones_restart", 128'(last_dones), 128'(DONES));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
